// File: rtl/manch_pkg.sv
// manch_pkg: shared state encoding and Manchester symbol constants
package manch_pkg;
  typedef enum logic {IDLE, DATA} state_t;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_ZERO = 2'b10;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  // Double-register the input so metastability settles before use
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q_o, meta_q} <= 2'b00;
    else {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/manchester_rx.sv
// manchester_rx: oversampled Manchester line decoder producing parallel words
module manchester_rx
  import manch_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              line_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              code_err,
  output logic              busy
);
  localparam int CNT_W = $clog2(2*HALF_BIT+1);
  localparam int IDX_W = $clog2(DATA_W+1);
  localparam logic [CNT_W-1:0] FIRST_WAIT = CNT_W'(HALF_BIT + HALF_BIT/2 - 1);
  localparam logic [CNT_W-1:0] HALF_WAIT  = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);
  logic              line_s, line_prev_q, rise_q;
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              half_q, first_q;
  logic [DATA_W-1:0] shift_q, shift_d, data_out_q;
  logic              data_valid_q, code_err_q;
  sync2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (line_in),
    .q_o  (line_s)
  );
  // Registered rising-edge flag on the synchronized line; marks the start mid-bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {line_prev_q, rise_q} <= 2'b00;
    else begin
      line_prev_q <= line_s;
      rise_q      <= line_s & ~line_prev_q;
    end
  // The decoded bit equals the second-half level, so shift that in
  always_comb shift_d = DATA_W'({shift_q, line_s});
  // Frame FSM: half-bit centre sampling, symbol check, word assembly and output pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      half_q       <= 1'b0;
      first_q      <= 1'b0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      if (!en) state_q <= IDLE;
      else if (state_q == IDLE) begin
        if (rise_q) begin
          state_q <= DATA;
          cnt_q   <= FIRST_WAIT;
          idx_q   <= '0;
          half_q  <= 1'b0;
          shift_q <= '0;
        end
      end else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else begin
        cnt_q  <= HALF_WAIT;
        half_q <= ~half_q;
        if (!half_q) first_q <= line_s;
        else if ({first_q, line_s} == SYM_ONE || {first_q, line_s} == SYM_ZERO) begin
          shift_q <= shift_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            data_out_q   <= shift_d;
            data_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end else begin
          code_err_q <= 1'b1;
          state_q    <= IDLE;
        end
      end
    end
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign code_err   = code_err_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_manchester_rx.sv
// tb_manchester_rx: scoreboard bench for the Manchester line decoder
module tb_manchester_rx;
  localparam int DW = 8;
  localparam int H  = 4;
  localparam int VALID_LAT = 3 + 2*DW*H + H/2 + 1;
  logic clk = 0, rst_n = 0, en = 0, line_in = 0;
  logic [DW-1:0] data_out;
  logic data_valid, code_err, busy;
  int checks = 0, passed = 0, cyc = 0, n_valid = 0, n_err = 0, err_cyc = -1;
  typedef struct {logic [DW-1:0] w; int c;} exp_t;
  exp_t sb[$];
  exp_t e;

  manchester_rx #(.DATA_W(DW), .HALF_BIT(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .line_in   (line_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .code_err  (code_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every data_valid pulse
  always @(negedge clk) begin
    if (code_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (data_valid) begin
      n_valid++;
      checks++;
      if (sb.size() == 0) $display("FAIL unexpected_valid: data_out=%h at cycle %0d, no frame pending", data_out, cyc);
      else begin
        passed++;
        e = sb.pop_front();
        checks++;
        if (data_out !== e.w) $display("FAIL valid_data: got %h expected %h", data_out, e.w);
        else passed++;
        checks++;
        if (cyc != e.c) $display("FAIL valid_cycle: got %0d expected %0d", cyc, e.c);
        else passed++;
      end
      checks++;
      if (busy !== 1'b0 || code_err !== 1'b0) $display("FAIL valid_flags: busy=%b code_err=%b expected 0 0", busy, code_err);
      else passed++;
    end
  end

  // Drives one frame from a negedge; stops before symbol 'abort' when abort >= 0
  task automatic send_frame(input logic [DW-1:0] w, input int bad, input int abort, output int l);
    logic f, s;
    line_in = 0;
    repeat (H) @(negedge clk);
    line_in = 1;
    l = cyc;
    if (bad < 0 && abort < 0) sb.push_back('{w, l + VALID_LAT});
    repeat (H) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b expected 1", busy);
    else passed++;
    for (int k = 0; k < DW; k++) begin
      if (k == abort) return;
      f = ~w[DW-1-k];
      s = w[DW-1-k];
      if (k == bad) s = f;
      line_in = f;
      repeat (H) @(negedge clk);
      line_in = s;
      repeat (H) @(negedge clk);
    end
    line_in = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout: %0d frames pending, expected 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    en = 1;
    for (int i = 0; i < 20; i++) begin
      line_in = i[0];
      @(negedge clk);
    end
    checks += 4;
    if (data_out !== '0) $display("FAIL reset_data: got %h expected 00", data_out); else passed++;
    if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", data_valid); else passed++;
    if (code_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", code_err); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    line_in = 0;
    rst_n = 1;
    repeat (100) @(negedge clk);
    checks += 3;
    if (n_valid != 0) $display("FAIL idle_valid: got %0d pulses expected 0", n_valid); else passed++;
    if (n_err != 0) $display("FAIL idle_err: got %0d pulses expected 0", n_err); else passed++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_single();
    int l, v0 = n_valid, e0 = n_err;
    send_frame(8'hA5, -1, -1, l);
    drain();
    checks += 3;
    if (data_out !== 8'hA5) $display("FAIL single_data: got %h expected a5", data_out); else passed++;
    if (n_valid != v0 + 1) $display("FAIL single_count: got %0d expected %0d", n_valid - v0, 1); else passed++;
    if (n_err != e0) $display("FAIL single_err: got %0d expected 0", n_err - e0); else passed++;
  endtask

  task automatic test_back_to_back();
    int l, v0 = n_valid;
    send_frame(8'h00, -1, -1, l);
    send_frame(8'hFF, -1, -1, l);
    drain();
    checks += 2;
    if (n_valid != v0 + 2) $display("FAIL b2b_count: got %0d expected 2", n_valid - v0); else passed++;
    if (data_out !== 8'hFF) $display("FAIL b2b_data: got %h expected ff", data_out); else passed++;
  endtask

  task automatic test_code_err();
    int l, v0 = n_valid, e0 = n_err;
    // Line goes idle right after the corrupted symbol so nothing later looks like a start edge
    send_frame(8'h3C, 4, 5, l);
    line_in = 0;
    repeat (60) @(negedge clk);
    checks += 4;
    if (n_err != e0 + 1) $display("FAIL err_count: got %0d expected 1", n_err - e0); else passed++;
    if (err_cyc != l + 3 + 10*H + H/2 + 1) $display("FAIL err_cycle: got %0d expected %0d", err_cyc, l + 3 + 10*H + H/2 + 1); else passed++;
    if (n_valid != v0) $display("FAIL err_valid: got %0d expected 0", n_valid - v0); else passed++;
    if (data_out !== 8'hFF) $display("FAIL err_hold: got %h expected ff", data_out); else passed++;
    send_frame(8'h81, -1, -1, l);
    drain();
    checks++;
    if (data_out !== 8'h81) $display("FAIL err_recover: got %h expected 81", data_out); else passed++;
  endtask

  task automatic test_en_drop();
    int l, v0 = n_valid, e0 = n_err;
    send_frame(8'h77, -1, 3, l);
    en = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL en_busy: got %b expected 0", busy); else passed++;
    repeat (9) @(negedge clk);
    line_in = 0;
    en = 1;
    repeat (10) @(negedge clk);
    checks += 2;
    if (n_valid != v0) $display("FAIL en_valid: got %0d expected 0", n_valid - v0); else passed++;
    if (n_err != e0) $display("FAIL en_err: got %0d expected 0", n_err - e0); else passed++;
    send_frame(8'h5A, -1, -1, l);
    drain();
    checks++;
    if (data_out !== 8'h5A) $display("FAIL en_data: got %h expected 5a", data_out); else passed++;
  endtask

  task automatic test_reset_mid();
    int l, v0, e0;
    send_frame(8'h99, -1, 5, l);
    rst_n = 0;
    #1;
    checks += 4;
    if (data_out !== '0) $display("FAIL rmid_data: got %h expected 00", data_out); else passed++;
    if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else passed++;
    if (data_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", data_valid); else passed++;
    if (code_err !== 1'b0) $display("FAIL rmid_err: got %b expected 0", code_err); else passed++;
    repeat (3) @(negedge clk);
    line_in = 0;
    rst_n = 1;
    v0 = n_valid;
    e0 = n_err;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid != v0 || n_err != e0) $display("FAIL rmid_pulse: got %0d/%0d expected 0/0", n_valid - v0, n_err - e0); else passed++;
    send_frame(8'hC3, -1, -1, l);
    drain();
    checks++;
    if (data_out !== 8'hC3) $display("FAIL rmid_recover: got %h expected c3", data_out); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_code_err();
    test_en_drop();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end
endmodule
